// File: rtl/decoder_onehot_pipe_pkg.sv
// Shared types and decode helpers for the one-hot decoder pipeline.
//   state_t        : occupancy of the head/skid output buffer.
//   onehot_decode  : address -> one-hot with enable and optional index mask.
//   is_masked      : true when an enabled decode hits the masked index.
// Helpers operate on MAX_ADDR_W-wide operands; callers zero-extend their
// address and truncate the result to their own output width.
package decoder_pkg;

  localparam int MAX_ADDR_W = 8;
  localparam int MAX_N_OUT  = 2 ** MAX_ADDR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic is_masked(
    input logic [MAX_ADDR_W-1:0] addr,
    input logic                  en,
    input logic                  mask_en,
    input logic [MAX_ADDR_W-1:0] mask_idx
  );
    return en & mask_en & (addr == mask_idx);
  endfunction

  function automatic logic [MAX_N_OUT-1:0] onehot_decode(
    input logic [MAX_ADDR_W-1:0] addr,
    input logic                  en,
    input logic                  mask_en,
    input logic [MAX_ADDR_W-1:0] mask_idx
  );
    logic [MAX_N_OUT-1:0] vec;
    vec = '0;
    if (en && !(mask_en && (addr == mask_idx))) begin
      vec[addr] = 1'b1;
    end else begin
      vec = '0;
    end
    return vec;
  endfunction

endpackage

// File: rtl/decoder_onehot_pipe_if.sv
// Handshake bundle for decoder_onehot_pipe.
//   upstream   : in_valid, in_ready, in_addr, in_en
//   downstream : out_valid, out_ready, out_onehot, out_addr
//   status     : drop_cnt (saturating count of masked enabled writes)
// slave is the decoder side, master is the side driving transactions in and
// accepting results.
interface decoder_onehot_pipe_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
);
  localparam int N_OUT = 2 ** ADDR_W;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic              in_en;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_onehot;
  logic [ADDR_W-1:0] out_addr;
  logic [CNT_W-1:0]  drop_cnt;

  modport slave (
    input  in_valid, in_addr, in_en, out_ready,
    output in_ready, out_valid, out_onehot, out_addr, drop_cnt
  );

  modport master (
    output in_valid, in_addr, in_en, out_ready,
    input  in_ready, out_valid, out_onehot, out_addr, drop_cnt
  );
endinterface

// File: rtl/decoder_onehot_pipe_dec.sv
// Combinational address decoder with enable and optional hardwired-zero mask.
// Reusable for write strobes and read-side selects.
//   addr   : index to decode
//   en     : 0 forces an all-zero result
//   onehot : 1 << addr, or zero when disabled or masked
//   masked : an enabled decode was suppressed by the mask
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter bit ZERO_MASK = 1'b1,
  parameter int MASK_IDX  = 2 ** ADDR_W - 1,
  localparam int N_OUT    = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [N_OUT-1:0]  onehot,
  output logic              masked
);

  localparam logic [MAX_ADDR_W-1:0] MASK_IDX_EXT = MAX_ADDR_W'(MASK_IDX);

  logic [MAX_ADDR_W-1:0] addr_ext_s;

  assign addr_ext_s = MAX_ADDR_W'(addr);
  // Upper bits of the wide helper result are always zero for in-range addresses.
  assign onehot     = N_OUT'(onehot_decode(addr_ext_s, en, ZERO_MASK, MASK_IDX_EXT));
  assign masked     = is_masked(addr_ext_s, en, ZERO_MASK, MASK_IDX_EXT);

endmodule

// File: rtl/decoder_onehot_pipe.sv
// Pipelined address-to-one-hot decoder with a 2-entry elastic output buffer.
// Decode happens at accept time; every output is driven from a register.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of decoder_onehot_pipe_if (handshake, decode, drop_cnt)
// The head register feeds out_*; the skid register absorbs one extra entry
// so in_ready can be registered and the block never drops a transaction.
module decoder_onehot_pipe
  import decoder_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter bit ZERO_MASK = 1'b1,
  parameter int MASK_IDX  = 2 ** ADDR_W - 1,
  parameter int CNT_W     = 8
) (
  input logic                  clk,
  input logic                  reset,
  decoder_onehot_pipe_if.slave bus
);

  localparam int N_OUT = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [N_OUT-1:0]  head_onehot_r;
  logic [ADDR_W-1:0] head_addr_r;
  logic [N_OUT-1:0]  skid_onehot_r;
  logic [ADDR_W-1:0] skid_addr_r;
  logic [CNT_W-1:0]  drop_cnt_r;

  logic              accept_s;
  logic              pop_s;
  logic [N_OUT-1:0]  dec_onehot_s;
  logic              dec_masked_s;

  onehot_dec #(
    .ADDR_W    (ADDR_W),
    .ZERO_MASK (ZERO_MASK),
    .MASK_IDX  (MASK_IDX)
  ) u_dec (
    .addr   (bus.in_addr),
    .en     (bus.in_en),
    .onehot (dec_onehot_s),
    .masked (dec_masked_s)
  );

  assign accept_s = bus.in_valid & in_ready_r;
  assign pop_s    = out_valid_r & bus.out_ready;

  // Buffer FSM: tracks occupancy and moves entries between input, head and skid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= EMPTY;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      head_onehot_r <= '0;
      head_addr_r   <= '0;
      skid_onehot_r <= '0;
      skid_addr_r   <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            head_onehot_r <= dec_onehot_s;
            head_addr_r   <= bus.in_addr;
            out_valid_r   <= 1'b1;
            state_r       <= ONE;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            // Old head leaves as the new entry takes its place: no bubble.
            head_onehot_r <= dec_onehot_s;
            head_addr_r   <= bus.in_addr;
          end else if (accept_s) begin
            skid_onehot_r <= dec_onehot_s;
            skid_addr_r   <= bus.in_addr;
            in_ready_r    <= 1'b0;
            state_r       <= FULL;
          end else if (pop_s) begin
            out_valid_r   <= 1'b0;
            state_r       <= EMPTY;
          end
        end
        FULL: begin
          if (pop_s) begin
            head_onehot_r <= skid_onehot_r;
            head_addr_r   <= skid_addr_r;
            in_ready_r    <= 1'b1;
            state_r       <= ONE;
          end
        end
        default: begin
          state_r     <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of enabled writes suppressed by the mask, taken at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_r <= '0;
    end else if (accept_s && dec_masked_s && (drop_cnt_r != CNT_MAX)) begin
      drop_cnt_r <= drop_cnt_r + CNT_W'(1);
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_onehot = head_onehot_r;
  assign bus.out_addr   = head_addr_r;
  assign bus.drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// Scoreboard bench: three decoders (default, mask disabled, 2-bit counter)
// share one stimulus stream; each has its own expected-response queue and
// drop counter computed from the decode rules.
module tb_decoder_onehot_pipe;

  typedef struct {
    logic [31:0] onehot;
    logic [4:0]  addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [4:0] in_addr = 5'd0;
  logic       in_en = 1'b0;
  logic       out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t sbq [3][$];
  int   mcnt [3];
  int   cnt_max [3] = '{255, 255, 3};
  bit   zmask [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  decoder_onehot_pipe_if #(.ADDR_W(5), .CNT_W(8)) ifa ();
  decoder_onehot_pipe_if #(.ADDR_W(5), .CNT_W(8)) ifb ();
  decoder_onehot_pipe_if #(.ADDR_W(5), .CNT_W(2)) ifc ();

  assign ifa.in_valid = in_valid;  assign ifa.in_addr = in_addr;
  assign ifa.in_en = in_en;        assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;  assign ifb.in_addr = in_addr;
  assign ifb.in_en = in_en;        assign ifb.out_ready = out_ready;
  assign ifc.in_valid = in_valid;  assign ifc.in_addr = in_addr;
  assign ifc.in_en = in_en;        assign ifc.out_ready = out_ready;

  decoder_onehot_pipe #(.ADDR_W(5), .ZERO_MASK(1'b1), .MASK_IDX(31), .CNT_W(8))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  decoder_onehot_pipe #(.ADDR_W(5), .ZERO_MASK(1'b0), .MASK_IDX(31), .CNT_W(8))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  decoder_onehot_pipe #(.ADDR_W(5), .ZERO_MASK(1'b1), .MASK_IDX(31), .CNT_W(2))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode: the write lands on register addr unless disabled or the zero register.
  function automatic logic [31:0] ref_onehot(input int addr, input bit en, input bit zm);
    if (en && !(zm && addr == 31)) return 32'd1 << addr;
    return 32'd0;
  endfunction

  // Monitor: compare all three DUTs against their queues once per cycle.
  always @(negedge clk) begin
    logic        ov [3];
    logic        ir [3];
    logic [31:0] oh [3];
    logic [4:0]  oa [3];
    int          dc [3];
    bit          m_ready;
    bit          m_valid;
    exp_t        e;
    ov[0] = ifa.out_valid; ir[0] = ifa.in_ready; oh[0] = ifa.out_onehot;
    oa[0] = ifa.out_addr;  dc[0] = int'(ifa.drop_cnt);
    ov[1] = ifb.out_valid; ir[1] = ifb.in_ready; oh[1] = ifb.out_onehot;
    oa[1] = ifb.out_addr;  dc[1] = int'(ifb.drop_cnt);
    ov[2] = ifc.out_valid; ir[2] = ifc.in_ready; oh[2] = ifc.out_onehot;
    oa[2] = ifc.out_addr;  dc[2] = int'(ifc.drop_cnt);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        sbq[i].delete();
        mcnt[i] = 0;
      end else begin
        m_ready = (sbq[i].size() < 2);
        m_valid = (sbq[i].size() > 0);
        check($sformatf("dut%0d in_ready", i), 64'(ir[i]), 64'(m_ready));
        check($sformatf("dut%0d out_valid", i), 64'(ov[i]), 64'(m_valid));
        check($sformatf("dut%0d drop_cnt", i), 64'(dc[i]), 64'(mcnt[i]));
        if (m_valid) begin
          check($sformatf("dut%0d out_onehot", i), 64'(oh[i]), 64'(sbq[i][0].onehot));
          check($sformatf("dut%0d out_addr", i), 64'(oa[i]), 64'(sbq[i][0].addr));
          if (out_ready) void'(sbq[i].pop_front());
        end
        if (in_valid && m_ready) begin
          e.onehot = ref_onehot(int'(in_addr), in_en, zmask[i]);
          e.addr   = in_addr;
          sbq[i].push_back(e);
          if (in_en && zmask[i] && in_addr == 5'd31 && mcnt[i] < cnt_max[i]) mcnt[i]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the current input until dut_a reports ready at a sampling point; bounded.
  task automatic wait_accept();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (ifa.in_ready) done = 1'b1;
      step();
    end
    if (!done) check("accept timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input int addr, input bit en);
    in_valid = 1'b1;
    in_addr  = 5'(addr);
    in_en    = en;
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  initial begin
    do_reset(2);

    // Basic decode
    out_ready = 1'b1;
    send(3, 1'b1);
    @(negedge clk);
    check("t1 onehot", 64'(ifa.out_onehot), 64'h8);
    check("t1 valid", 64'(ifa.out_valid), 64'd1);
    step();

    // Masked zero register, with and without the mask
    repeat (3) send(31, 1'b1);
    @(negedge clk);
    check("t2 drop_cnt masked", 64'(ifa.drop_cnt), 64'd3);
    check("t2 drop_cnt unmasked", 64'(ifb.drop_cnt), 64'd0);
    check("t2 onehot unmasked", 64'(ifb.out_onehot), 64'h8000_0000);
    check("t2 onehot masked", 64'(ifa.out_onehot), 64'd0);
    step();
    repeat (2) step();

    // Backpressure: third transaction waits upstream
    out_ready = 1'b0;
    send(1, 1'b1);
    send(2, 1'b1);
    in_valid = 1'b1; in_addr = 5'd4; in_en = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("t3 in_ready stalled", 64'(ifa.in_ready), 64'd0);
    check("t3 head stable", 64'(ifa.out_onehot), 64'h2);
    step();
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (4) step();

    // Disabled decode still passes through
    send(7, 1'b0);
    @(negedge clk);
    check("t4 onehot", 64'(ifa.out_onehot), 64'd0);
    check("t4 addr", 64'(ifa.out_addr), 64'd7);
    step();

    // Streaming every address back to back
    for (int a = 0; a < 32; a++) begin
      in_valid = 1'b1; in_addr = 5'(a); in_en = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Saturation of the narrow counter, then reset with a full buffer
    do_reset(1);
    repeat (5) send(31, 1'b1);
    @(negedge clk);
    check("t6 sat cnt2", 64'(ifc.drop_cnt), 64'd3);
    check("t6 cnt8", 64'(ifa.drop_cnt), 64'd5);
    step();
    out_ready = 1'b0;
    send(9, 1'b1);
    send(10, 1'b1);
    do_reset(1);
    @(negedge clk);
    check("t6 reset valid", 64'(ifc.out_valid), 64'd0);
    check("t6 reset cnt", 64'(ifc.drop_cnt), 64'd0);
    check("t6 reset ready", 64'(ifc.in_ready), 64'd1);
    step();

    // Randomised traffic, with one reset in the middle
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_addr   = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      in_en     = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      reset     = (c == 200);
      step();
    end
    reset = 1'b0;

    // Drain
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("drain empty", 64'(ifa.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
